// File: rtl/hybridsub8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : hybridsub8_pipe
// Brief    : Two-stage pipelined 8-bit subtractor D = X - Y - Bin. Stage 1 is a
//            6-bit carry lookahead, stage 2 ripples bits 7:6. Both sides use a
//            valid/ready handshake. Optional macro HYBRIDSUB8_SAT_EN enables
//            unsigned saturation to zero on borrow-out.
// Revision : 1.0 - initial release
// ============================================================================
module hybridsub8_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] Xi,
  input  logic [7:0] Yi,
  input  logic       Bin,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] Di,
  output logic       Bout,
  output logic       Vout,
  output logic       Zout
);

  logic       s1_valid_q, s1_valid_d;
  logic [5:0] s1_dlo_q,   s1_dlo_d;
  logic       s1_c6_q,    s1_c6_d;
  logic [1:0] s1_xhi_q,   s1_xhi_d;
  logic [1:0] s1_nyhi_q,  s1_nyhi_d;

  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_diff_q,  s2_diff_d;
  logic       s2_bout_q,  s2_bout_d;
  logic       s2_vout_q,  s2_vout_d;
  logic       s2_zout_q,  s2_zout_d;

  logic       s1_adv;
  logic       in_xfer;
  logic       out_xfer;

  logic [5:0] p;
  logic [5:0] g;
  logic [6:0] c;
  logic       c7;
  logic       c8;
  logic [7:0] diff_raw;

  // Handshake: stage 1 may move whenever stage 2 is empty or draining.
  always_comb begin
    out_xfer = s2_valid_q & out_ready;
    s1_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = ~rst & (~s1_valid_q | s1_adv);
    in_xfer  = in_valid & in_ready;
  end

  // Stage 1: subtract as X + ~Y + ~Bin with flat two-level lookahead.
  always_comb begin
    p    = Xi[5:0] ^ ~Yi[5:0];
    g    = Xi[5:0] & ~Yi[5:0];
    c[0] = ~Bin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
         | (p[4] & p[3] & p[2] & g[1])
         | (p[4] & p[3] & p[2] & p[1] & g[0])
         | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & g[3])
         | (p[5] & p[4] & p[3] & g[2])
         | (p[5] & p[4] & p[3] & p[2] & g[1])
         | (p[5] & p[4] & p[3] & p[2] & p[1] & g[0])
         | (p[5] & p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
  end

  // Stage 2: ripple the upper two bits from the registered C6.
  always_comb begin
    c7       = (s1_xhi_q[0] & s1_nyhi_q[0])
             | ((s1_xhi_q[0] ^ s1_nyhi_q[0]) & s1_c6_q);
    c8       = (s1_xhi_q[1] & s1_nyhi_q[1])
             | ((s1_xhi_q[1] ^ s1_nyhi_q[1]) & c7);
    diff_raw = {s1_xhi_q[1] ^ s1_nyhi_q[1] ^ c7,
                s1_xhi_q[0] ^ s1_nyhi_q[0] ^ s1_c6_q,
                s1_dlo_q};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_dlo_d   = s1_dlo_q;
    s1_c6_d    = s1_c6_q;
    s1_xhi_d   = s1_xhi_q;
    s1_nyhi_d  = s1_nyhi_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_dlo_d   = p ^ c[5:0];
      s1_c6_d    = c[6];
      s1_xhi_d   = Xi[7:6];
      s1_nyhi_d  = ~Yi[7:6];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    s2_diff_d  = s2_diff_q;
    s2_bout_d  = s2_bout_q;
    s2_vout_d  = s2_vout_q;
    s2_zout_d  = s2_zout_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_bout_d  = ~c8;
      s2_vout_d  = c8 ^ c7;
`ifdef HYBRIDSUB8_SAT_EN
      // A borrow means the true result is negative: clamp to zero.
      if (~c8) begin
        s2_diff_d = 8'h00;
        s2_zout_d = 1'b1;
      end else begin
        s2_diff_d = diff_raw;
        s2_zout_d = ~|diff_raw;
      end
`else
      s2_diff_d  = diff_raw;
      s2_zout_d  = ~|diff_raw;
`endif
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dlo_q   <= 6'h00;
      s1_c6_q    <= 1'b0;
      s1_xhi_q   <= 2'b00;
      s1_nyhi_q  <= 2'b00;
      s2_valid_q <= 1'b0;
      s2_diff_q  <= 8'h00;
      s2_bout_q  <= 1'b0;
      s2_vout_q  <= 1'b0;
      s2_zout_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_dlo_q   <= s1_dlo_d;
      s1_c6_q    <= s1_c6_d;
      s1_xhi_q   <= s1_xhi_d;
      s1_nyhi_q  <= s1_nyhi_d;
      s2_valid_q <= s2_valid_d;
      s2_diff_q  <= s2_diff_d;
      s2_bout_q  <= s2_bout_d;
      s2_vout_q  <= s2_vout_d;
      s2_zout_q  <= s2_zout_d;
    end
  end

  always_comb begin
    out_valid = s2_valid_q;
    Di        = s2_diff_q;
    Bout      = s2_bout_q;
    Vout      = s2_vout_q;
    Zout      = s2_zout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hybridsub8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_hybridsub8_pipe
// Brief    : Scoreboard bench for hybridsub8_pipe; an arithmetic reference
//            model feeds an expected-result queue drained by an output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hybridsub8_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] Xi = 8'h00;
  logic [7:0] Yi = 8'h00;
  logic       Bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] Di;
  logic       Bout;
  logic       Vout;
  logic       Zout;

  int n_checks = 0;
  int n_pass   = 0;
  logic rand_bp = 1'b0;

  logic [10:0] exp_q[$];
  logic        hold_q = 1'b0;
  logic [10:0] hold_val = '0;

  hybridsub8_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Xi(Xi), .Yi(Yi), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Di(Di), .Bout(Bout), .Vout(Vout), .Zout(Zout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on the operands, packed {D,B,V,Z}.
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic b);
    int ud, sd, sx, sy;
    logic [7:0] d;
    logic bo, v, z;
    sx = $signed(x);
    sy = $signed(y);
    ud = int'(x) - int'(y) - int'(b);
    sd = sx - sy - int'(b);
    d  = 8'(ud & 255);
    bo = (ud < 0);
    v  = (sd < -128) || (sd > 127);
    z  = (d == 8'h00);
`ifdef HYBRIDSUB8_SAT_EN
    if (bo) begin
      d = 8'h00;
      z = 1'b1;
    end
`endif
    return {d, bo, v, z};
  endfunction

  // Input capture and output monitor, both sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_data_held", {21'd0, Di, Bout, Vout, Zout}, {21'd0, hold_val});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0)
          chk("unexpected_beat", {21'd0, Di, Bout, Vout, Zout}, 32'hFFFF_FFFF);
        else
          chk("result", {21'd0, Di, Bout, Vout, Zout}, {21'd0, exp_q.pop_front()});
      end
      hold_q   = out_valid && !out_ready;
      hold_val = {Di, Bout, Vout, Zout};
      if (in_valid && in_ready) exp_q.push_back(model(Xi, Yi, Bin));
    end
  end

  // Present one beat and wait for its transfer edge; returns stalled cycles.
  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic b, output int waits);
    logic acc;
    Xi = x; Yi = y; Bin = b; in_valid = 1'b1;
    waits = 0;
    forever begin
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 60) begin
        chk("push_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
  endtask

  logic [7:0] dx[5] = '{8'h10, 8'h80, 8'h40, 8'h3F, 8'hFF};
  logic [7:0] dy[5] = '{8'h20, 8'h01, 8'h40, 8'h3F, 8'h00};
  logic       db[5] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1};

  initial begin
    int w;
    logic [7:0] rx, ry;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {21'd0, Di, Bout, Vout, Zout}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single beat latency
    push(8'h50, 8'h20, 1'b0, w);
    chk("single_out_valid_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_value", {21'd0, Di, Bout, Vout, Zout}, {21'd0, 8'h30, 3'b000});
    @(posedge clk); #1;

    // Directed corner operands
    for (int i = 0; i < 5; i++) push(dx[i], dy[i], db[i], w);
    drain();

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      push(8'($urandom), 8'($urandom), 1'($urandom), w);
      chk("stream_no_stall", w, 32'd0);
      if (i >= 1) chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
    end
    chk("stream_tail_valid", {31'd0, out_valid}, 32'd1);
    drain();

    // Backpressure: two beats fill the pipe, third must stall
    out_ready = 1'b0;
    push(8'h77, 8'h11, 1'b0, w);
    chk("bp_first_accept", w, 32'd0);
    push(8'h05, 8'h09, 1'b1, w);
    chk("bp_second_accept", w, 32'd0);
    Xi = 8'hC3; Yi = 8'h3C; Bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(8'hC3, 8'h3C, 1'b0, w);
    drain();

    // Mid-operation reset with both stages full
    out_ready = 1'b0;
    push(8'h12, 8'h34, 1'b0, w);
    push(8'h56, 8'h78, 1'b1, w);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_outputs", {21'd0, Di, Bout, Vout, Zout}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_post_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);

    // Randomized traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: rx = 8'h00;
        1: rx = 8'hFF;
        2: rx = 8'h80;
        default: rx = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: ry = 8'h00;
        1: ry = 8'h7F;
        2: ry = rx;
        default: ry = 8'($urandom);
      endcase
      push(rx, ry, 1'($urandom), w);
      if ($urandom_range(0, 4) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    rand_bp = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
